vm_inventory_store: RTL

- Capacity store for the vending machine: 6 lines x 8 columns of 5-bit item counts.
- Sits downstream of the admin stage. Consumes its signed capacity delta, position and verify strobe, and commits the delta into the addressed slot.
- Also serves customer purchases: checks the slot, decrements it and drives a timed dispense-motor pulse.
- Feeds current capacities back to the admin stage and to the display.

---
 rtl/vm_pkg.sv | 36 +++
 rtl/vm_dispense_timer.sv | 47 ++++
 rtl/vm_inventory_store.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared constants, FSM state type and slot-addressing helpers for the
// vending-machine inventory path.
package vm_pkg;

  localparam int NUM_LINES = 6;
  localparam int NUM_COLS  = 8;
  localparam int CAP_W     = 5;
  localparam int NUM_SLOTS = NUM_LINES * NUM_COLS;
  localparam int FLAT_W    = NUM_SLOTS * CAP_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADMIN_WR  = 2'd1,
    ST_BUY_CHECK = 2'd2,
    ST_DISPENSE  = 2'd3
  } state_e;

  // Line 1 only populates the odd columns; lines 2..6 are fully populated.
  function automatic logic pos_valid(input logic [2:0] line, input logic [3:0] column);
    logic ok;
    ok = (line >= 3'd1) && (line <= 3'd6) && (column >= 4'd1) && (column <= 4'd8);
    if (line == 3'd1) begin
      ok = ok && column[0];
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  function automatic logic [5:0] slot_index(input logic [2:0] line, input logic [3:0] column);
    logic [5:0] idx;
    idx = ({3'd0, line} - 6'd1) * 6'd8 + ({2'd0, column} - 6'd1);
    return idx;
  endfunction

endpackage

// File: rtl/vm_dispense_timer.sv
// Dispense-motor timer: a load starts a DISPENSE_CYCLES-long motor pulse,
// with a one-cycle done pulse on the cycle the motor drops.
module vm_dispense_timer #(
  parameter int DISPENSE_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic motor_o,
  output logic done_o,
  output logic last_o
);

  localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DISPENSE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             motor_q;
  logic             done_q;

  // Count down while the motor runs; the zero count ends the pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= {CNT_W{1'b0}};
      motor_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        cnt_q   <= LOAD_VAL;
        motor_q <= 1'b1;
      end else if (motor_q) begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          motor_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign motor_o = motor_q;
  assign done_o  = done_q;
  assign last_o  = motor_q && (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/vm_inventory_store.sv
// Slot-count store for the vending machine: serialises admin capacity commits
// and customer purchases through one FSM and drives the dispense motor.
module vm_inventory_store
  import vm_pkg::*;
#(
  parameter int MAX_CAP         = 9,
  parameter int INIT_CAP        = 5,
  parameter int DISPENSE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              admin_commit,
  input  logic [2:0]        admin_line,
  input  logic [3:0]        admin_column,
  input  logic [4:0]        admin_delta,
  input  logic              buy_req,
  input  logic [2:0]        buy_line,
  input  logic [3:0]        buy_column,
  output logic [FLAT_W-1:0] capacity_flat,
  output logic              busy,
  output logic              dispense_motor,
  output logic              buy_done,
  output logic              buy_empty,
  output logic              buy_invalid,
  output logic              buy_drop,
  output logic              admin_done,
  output logic              admin_reject
);

  localparam logic signed [6:0] MAX_S = 7'(MAX_CAP);
  localparam logic [CAP_W-1:0]  MAX_C = CAP_W'(MAX_CAP);

  function automatic logic [CAP_W-1:0] init_count(input int idx);
    return pos_valid(3'(idx / NUM_COLS + 1), 4'(idx % NUM_COLS + 1)) ?
           CAP_W'(INIT_CAP) : {CAP_W{1'b0}};
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       adm_line_q, adm_line_d, buy_line_q, buy_line_d;
  logic [3:0]       adm_col_q, adm_col_d, buy_col_q, buy_col_d;
  logic [4:0]       adm_delta_q, adm_delta_d;
  logic             adm_pend_q, adm_pend_d;
  logic             busy_q, busy_d;
  logic             admin_done_q, admin_done_d, admin_reject_q, admin_reject_d;
  logic             buy_empty_q, buy_empty_d, buy_invalid_q, buy_invalid_d;
  logic             buy_drop_q, buy_drop_d;
  logic [CAP_W-1:0] cap_q [NUM_SLOTS];

  logic             adm_valid_s, buy_valid_s;
  logic [5:0]       adm_idx_s, buy_idx_s, wr_idx_s;
  logic [CAP_W-1:0] adm_cur_s, buy_cur_s, adm_new_s, wr_val_s;
  logic signed [6:0] sum_s;
  logic             wr_en_s, tmr_load_s, tmr_last_s;

  // Address decode and clamped admin update value for the captured commit.
  always_comb begin
    adm_valid_s = pos_valid(adm_line_q, adm_col_q);
    buy_valid_s = pos_valid(buy_line_q, buy_col_q);
    adm_idx_s   = adm_valid_s ? slot_index(adm_line_q, adm_col_q) : 6'd0;
    buy_idx_s   = buy_valid_s ? slot_index(buy_line_q, buy_col_q) : 6'd0;
    adm_cur_s   = cap_q[adm_idx_s];
    buy_cur_s   = cap_q[buy_idx_s];
    sum_s = $signed({2'b00, adm_cur_s}) + $signed({{2{adm_delta_q[4]}}, adm_delta_q});
    if (sum_s < 7'sd0) begin
      adm_new_s = {CAP_W{1'b0}};
    end else if (sum_s > MAX_S) begin
      adm_new_s = MAX_C;
    end else begin
      adm_new_s = sum_s[CAP_W-1:0];
    end
  end

  // Next-state, capture and pulse logic of the request-serialising FSM.
  always_comb begin
    state_d        = state_q;
    adm_line_d     = adm_line_q;
    adm_col_d      = adm_col_q;
    adm_delta_d    = adm_delta_q;
    adm_pend_d     = adm_pend_q;
    buy_line_d     = buy_line_q;
    buy_col_d      = buy_col_q;
    admin_done_d   = 1'b0;
    admin_reject_d = 1'b0;
    buy_empty_d    = 1'b0;
    buy_invalid_d  = 1'b0;
    buy_drop_d     = 1'b0;
    wr_en_s        = 1'b0;
    wr_idx_s       = 6'd0;
    wr_val_s       = {CAP_W{1'b0}};
    tmr_load_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (admin_commit || adm_pend_q) begin
          state_d    = ST_ADMIN_WR;
          adm_pend_d = 1'b0;
          if (admin_commit) begin
            adm_line_d  = admin_line;
            adm_col_d   = admin_column;
            adm_delta_d = admin_delta;
          end else begin
            adm_line_d  = adm_line_q;
          end
          buy_drop_d = buy_req;
        end else if (buy_req) begin
          state_d    = ST_BUY_CHECK;
          buy_line_d = buy_line;
          buy_col_d  = buy_column;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADMIN_WR: begin
        state_d = ST_IDLE;
        if (adm_valid_s) begin
          wr_en_s      = 1'b1;
          wr_idx_s     = adm_idx_s;
          wr_val_s     = adm_new_s;
          admin_done_d = 1'b1;
        end else begin
          admin_reject_d = 1'b1;
        end
      end
      ST_BUY_CHECK: begin
        if (!buy_valid_s) begin
          buy_invalid_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (buy_cur_s == {CAP_W{1'b0}}) begin
          buy_empty_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wr_en_s    = 1'b1;
          wr_idx_s   = buy_idx_s;
          wr_val_s   = buy_cur_s - {{(CAP_W-1){1'b0}}, 1'b1};
          tmr_load_s = 1'b1;
          state_d    = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (tmr_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DISPENSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // While busy, the newest admin commit is parked for the next IDLE visit.
    if (state_q != ST_IDLE) begin
      if (admin_commit) begin
        adm_pend_d  = 1'b1;
        adm_line_d  = admin_line;
        adm_col_d   = admin_column;
        adm_delta_d = admin_delta;
      end else begin
        adm_pend_d = adm_pend_d;
      end
      buy_drop_d = buy_req;
    end else begin
      buy_drop_d = buy_drop_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, captured request fields and registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      adm_line_q     <= 3'd0;
      adm_col_q      <= 4'd0;
      adm_delta_q    <= 5'd0;
      adm_pend_q     <= 1'b0;
      buy_line_q     <= 3'd0;
      buy_col_q      <= 4'd0;
      busy_q         <= 1'b0;
      admin_done_q   <= 1'b0;
      admin_reject_q <= 1'b0;
      buy_empty_q    <= 1'b0;
      buy_invalid_q  <= 1'b0;
      buy_drop_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      adm_line_q     <= adm_line_d;
      adm_col_q      <= adm_col_d;
      adm_delta_q    <= adm_delta_d;
      adm_pend_q     <= adm_pend_d;
      buy_line_q     <= buy_line_d;
      buy_col_q      <= buy_col_d;
      busy_q         <= busy_d;
      admin_done_q   <= admin_done_d;
      admin_reject_q <= admin_reject_d;
      buy_empty_q    <= buy_empty_d;
      buy_invalid_q  <= buy_invalid_d;
      buy_drop_q     <= buy_drop_d;
    end
  end

  // Slot storage: single write port shared by admin writes and purchases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cap_q[i] <= init_count(i);
      end
    end else if (wr_en_s) begin
      cap_q[wr_idx_s] <= wr_val_s;
    end
  end

  vm_dispense_timer #(
    .DISPENSE_CYCLES (DISPENSE_CYCLES)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (tmr_load_s),
    .motor_o (dispense_motor),
    .done_o  (buy_done),
    .last_o  (tmr_last_s)
  );

  // Flatten the slot registers onto the display/admin feedback bus.
  always_comb begin
    capacity_flat = {FLAT_W{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      capacity_flat[i*CAP_W +: CAP_W] = cap_q[i];
    end
  end

  assign busy         = busy_q;
  assign admin_done   = admin_done_q;
  assign admin_reject = admin_reject_q;
  assign buy_empty    = buy_empty_q;
  assign buy_invalid  = buy_invalid_q;
  assign buy_drop     = buy_drop_q;

endmodule
